gauss_sample_collector: RTL and testbench
=========================================

// Module: gauss_sample_collector
// PURPOSE
//  Host-side consumer of the BoxMuller Gaussian generator. Arms the generator,
//  drives its control_bit and qualifies each result with invalid/complete. Keeps
//  accepted 32-bit samples, up to a programmable target count, in a FIFO.
//  The FPGA_IF host side drains the FIFO. Sits between the generator and the bus.
// PARAMETERS
//  DATA_W      32   sample width (matches g_randnum_out)
//  ADDR_W      4    FIFO address width; depth = 2**ADDR_W = 16
//  CNT_W       16   width of target and statistics counters
// PORTS
//  clk             in   1       system clock
//  reset           in   1       synchronous, active-high reset
//  start           in   1       pulse: begin a run (ignored unless IDLE or DONE)
//  abort           in   1       pulse: end the current run immediately
//  target_cnt      in   CNT_W   number of accepted samples to collect; sampled on start
//  gen_nreset      out  1       active-low reset to the generator
//  gen_control_bit out  1       generator run enable
//  gen_randnum     in   DATA_W  generator sample
//  gen_invalid_bit in   1       1 = rejected sample this cycle
//  gen_complete_bit in  1       1 = generator sequence exhausted (sticky)
//  rd_en           in   1       host read strobe
//  rd_data         out  DATA_W  FIFO head, registered
//  rd_valid        out  1       rd_data valid (1 cycle after an accepted rd_en)
//  fifo_empty      out  1       FIFO level == 0
//  fifo_full       out  1       FIFO level == 2**ADDR_W
//  busy            out  1       state is ARM or COLLECT
//  done            out  1       state is DONE
//  gen_exhausted   out  1       run ended on gen_complete_bit before reaching target
//  accepted_cnt    out  CNT_W   samples written to the FIFO in this run
//  rejected_cnt    out  CNT_W   cycles in COLLECT with invalid=1; saturates at all-ones
//  overflow_cnt    out  CNT_W   valid samples dropped on a full FIFO; saturates
// BEHAVIOUR
//  Reset: state=IDLE; gen_nreset=0; gen_control_bit=0; rd_data=0; rd_valid=0.
//   Reset also clears the FIFO pointers and level, all counters, busy, done and
//   gen_exhausted. Reset wins over every other input.
//  FSM IDLE -> ARM -> COLLECT -> DONE -> (start) ARM.
//   IDLE: gen_nreset=0, control=0. start -> ARM. Latch target_cnt into tgt.
//   ARM (exactly 1 cycle): gen_nreset=0, control=0.
//    - Flush FIFO; clear counters and gen_exhausted.
//    - tgt==0 -> DONE, else -> COLLECT.
//   COLLECT: gen_nreset=1, control=1. Each cycle is classified as:
//    - complete=1          : no write; gen_exhausted=1; -> DONE
//    - invalid=1           : rejected_cnt++
//    - else (valid sample) : if FIFO not full, or rd_en accepted this cycle,
//                            write gen_randnum and accepted_cnt++;
//                            otherwise drop and overflow_cnt++.
//    - accepted_cnt reaches tgt on a write -> DONE next cycle; no further samples taken.
//    - abort -> DONE (a valid sample in the same cycle is still taken).
//    - Priority: complete > abort/target; complete and invalid together count as complete only.
//   DONE: gen_nreset=1, control=0, done=1; counters frozen. start -> ARM.
//   start in ARM or COLLECT is ignored. abort outside COLLECT is ignored.
//  FIFO: DATA_W x 2**ADDR_W, separate read/write pointers that wrap modulo depth,
//   plus a level counter of ADDR_W+1 bits.
//   - Host reads are legal in every state, including IDLE and DONE.
//   - rd_en when empty: ignored, rd_valid=0, rd_data holds its value.
//   - rd_en when not empty: rd_data=head and rd_valid=1 on the next cycle;
//     rd_valid is a single-cycle pulse per read.
//   - Read and write in the same cycle: level unchanged; the write is legal even when full.
//   - The ARM flush discards unread data, and any read in the ARM cycle is ignored.
//  Latency: a generator sample reaches rd_data no earlier than 2 cycles after
//   presentation (1 cycle write, 1 cycle read).
// TESTING
//  T1: target=4, invalid pattern 0,1,0,0,1,0 -> accepted=4, rejected=2, DONE; 4 reads return samples in order.
//  T2: target=20, never read, all valid -> 16 written, fifo_full=1, overflow_cnt=4, accepted=16, no DONE until read.
//  T3: full FIFO with rd_en and a valid sample in the same cycle -> level stays 16; the new sample becomes the tail.
//  T4: target=100, gen_complete_bit after 7 valid -> DONE, gen_exhausted=1, accepted=7, control falls next cycle.
//  T5: start with target=0 -> ARM, then DONE in 2 cycles, accepted=0, control never asserted.
//  T6: reset asserted mid-COLLECT with 5 queued -> next cycle IDLE, fifo_empty=1, counters=0, gen_nreset=0.

Source files
------------

// File: rtl/gauss_sample_collector.sv
// Host-side collector for the Box-Muller Gaussian generator: arms the
// generator, qualifies its samples and buffers accepted ones in a FIFO.
module gauss_sample_collector #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  target_cnt,
  output logic              gen_nreset,
  output logic              gen_control_bit,
  input  logic [DATA_W-1:0] gen_randnum,
  input  logic              gen_invalid_bit,
  input  logic              gen_complete_bit,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              busy,
  output logic              done,
  output logic              gen_exhausted,
  output logic [CNT_W-1:0]  accepted_cnt,
  output logic [CNT_W-1:0]  rejected_cnt,
  output logic [CNT_W-1:0]  overflow_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    tgt_q, tgt_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    rej_q, rej_d;
  logic [CNT_W-1:0]    ovf_q, ovf_d;
  logic                exh_q, exh_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                nreset_q, nreset_d;
  logic                ctrl_q, ctrl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                rd_acc_c;
  logic                wr_en_c;

  // FSM next state, sample classification, counters and FIFO bookkeeping
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    acc_d      = acc_q;
    rej_d      = rej_q;
    ovf_d      = ovf_q;
    exh_d      = exh_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_en_c    = 1'b0;
    rd_acc_c   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ARM;
          tgt_d   = target_cnt;
        end
      end
      S_ARM: begin
        acc_d = '0;
        rej_d = '0;
        ovf_d = '0;
        exh_d = 1'b0;
        state_d = (tgt_q == '0) ? S_DONE : S_COLLECT;
      end
      S_COLLECT: begin
        // A read this cycle frees a slot, so a full FIFO can still take a write
        rd_acc_c = rd_en && (level_q != '0);
        if (gen_complete_bit) begin
          exh_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          if (gen_invalid_bit) begin
            if (rej_q != '1) rej_d = rej_q + CNT_W'(1);
          end else if (!full_q || rd_acc_c) begin
            wr_en_c = 1'b1;
            acc_d   = acc_q + CNT_W'(1);
            if (acc_d == tgt_q) state_d = S_DONE;
          end else begin
            if (ovf_q != '1) ovf_d = ovf_q + CNT_W'(1);
          end
          if (abort) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_ARM && state_q != S_COLLECT) rd_acc_c = rd_en && (level_q != '0);

    if (state_q == S_ARM) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc_c) begin
        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      if (wr_en_c && !rd_acc_c) level_d = level_q + LVL_W'(1);
      else if (rd_acc_c && !wr_en_c) level_d = level_q - LVL_W'(1);
    end

    empty_d  = (level_d == '0);
    full_d   = (level_d == LVL_W'(DEPTH));
    nreset_d = (state_d == S_COLLECT) || (state_d == S_DONE);
    ctrl_d   = (state_d == S_COLLECT);
    busy_d   = (state_d == S_ARM) || (state_d == S_COLLECT);
    done_d   = (state_d == S_DONE);
  end

  // State, counters, FIFO control and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      acc_q      <= '0;
      rej_q      <= '0;
      ovf_q      <= '0;
      exh_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      nreset_q   <= 1'b0;
      ctrl_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      acc_q      <= acc_d;
      rej_q      <= rej_d;
      ovf_q      <= ovf_d;
      exh_q      <= exh_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      nreset_q   <= nreset_d;
      ctrl_q     <= ctrl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // FIFO storage; contents need no reset since the level gates every read
  always_ff @(posedge clk) begin
    if (!reset && wr_en_c) mem_q[wr_ptr_q] <= gen_randnum;
  end

  assign gen_nreset      = nreset_q;
  assign gen_control_bit = ctrl_q;
  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign fifo_empty      = empty_q;
  assign fifo_full       = full_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign gen_exhausted   = exh_q;
  assign accepted_cnt    = acc_q;
  assign rejected_cnt    = rej_q;
  assign overflow_cnt    = ovf_q;

endmodule

// File: tb/tb_gauss_sample_collector.sv
// Directed bench for gauss_sample_collector.
module tb_gauss_sample_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] target_cnt;
  logic        gen_nreset;
  logic        gen_control_bit;
  logic [31:0] gen_randnum;
  logic        gen_invalid_bit;
  logic        gen_complete_bit;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic        busy;
  logic        done;
  logic        gen_exhausted;
  logic [15:0] accepted_cnt;
  logic [15:0] rejected_cnt;
  logic [15:0] overflow_cnt;

  int checks = 0;
  int errors = 0;

  gauss_sample_collector dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .target_cnt       (target_cnt),
    .gen_nreset       (gen_nreset),
    .gen_control_bit  (gen_control_bit),
    .gen_randnum      (gen_randnum),
    .gen_invalid_bit  (gen_invalid_bit),
    .gen_complete_bit (gen_complete_bit),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .busy             (busy),
    .done             (done),
    .gen_exhausted    (gen_exhausted),
    .accepted_cnt     (accepted_cnt),
    .rejected_cnt     (rejected_cnt),
    .overflow_cnt     (overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; target_cnt = '0;
    gen_randnum = '0; gen_invalid_bit = 1'b0; gen_complete_bit = 1'b0; rd_en = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_nreset", 32'(gen_nreset), 32'd0);
    chk("rst_ctrl", 32'(gen_control_bit), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_acc", 32'(accepted_cnt), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // T1: target 4, invalid pattern 0,1,0,0,1,0
    target_cnt = 16'd4; start = 1'b1;
    step();
    start = 1'b0; target_cnt = 16'd0;
    chk("t1_arm_busy", 32'(busy), 32'd1);
    chk("t1_arm_ctrl", 32'(gen_control_bit), 32'd0);
    chk("t1_arm_nreset", 32'(gen_nreset), 32'd0);
    step();
    chk("t1_col_ctrl", 32'(gen_control_bit), 32'd1);
    chk("t1_col_nreset", 32'(gen_nreset), 32'd1);
    for (int i = 0; i < 6; i++) begin
      gen_randnum = 32'hA000_0000 + 32'(i);
      gen_invalid_bit = (i == 1) || (i == 4);
      step();
    end
    gen_invalid_bit = 1'b0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_ctrl", 32'(gen_control_bit), 32'd0);
    chk("t1_nreset", 32'(gen_nreset), 32'd1);
    chk("t1_acc", 32'(accepted_cnt), 32'd4);
    chk("t1_rej", 32'(rejected_cnt), 32'd2);
    chk("t1_rd0", rd_data, 32'd0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("t1_v0", 32'(rd_valid), 32'd1); chk("t1_d0", rd_data, 32'hA000_0000);
    step();
    chk("t1_pulse", 32'(rd_valid), 32'd0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("t1_v1", 32'(rd_valid), 32'd1); chk("t1_d1", rd_data, 32'hA000_0002);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("t1_v2", 32'(rd_valid), 32'd1); chk("t1_d2", rd_data, 32'hA000_0003);
    rd_en = 1'b1; step();
    chk("t1_v3", 32'(rd_valid), 32'd1); chk("t1_d3", rd_data, 32'hA000_0005);
    chk("t1_empty", 32'(fifo_empty), 32'd1);
    step(); rd_en = 1'b0;
    chk("t1_empty_rd_valid", 32'(rd_valid), 32'd0);
    chk("t1_empty_rd_hold", rd_data, 32'hA000_0005);

    // T2: target 20, no reads, all valid
    target_cnt = 16'd20; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      gen_randnum = 32'hB000_0000 + 32'(i);
      step();
    end
    chk("t2_full", 32'(fifo_full), 32'd1);
    chk("t2_acc", 32'(accepted_cnt), 32'd16);
    chk("t2_ovf", 32'(overflow_cnt), 32'd4);
    chk("t2_done", 32'(done), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);

    // T3: full FIFO, read and valid sample together
    rd_en = 1'b1; gen_randnum = 32'hC000_0000;
    step();
    chk("t3_v", 32'(rd_valid), 32'd1);
    chk("t3_head", rd_data, 32'hB000_0000);
    chk("t3_full", 32'(fifo_full), 32'd1);
    chk("t3_acc", 32'(accepted_cnt), 32'd17);
    chk("t3_ovf", 32'(overflow_cnt), 32'd4);
    gen_invalid_bit = 1'b1;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("t3_drain", rd_data, 32'hB000_0000 + 32'(i));
    end
    step();
    chk("t3_tail", rd_data, 32'hC000_0000);
    chk("t3_empty", 32'(fifo_empty), 32'd1);
    chk("t3_rej", 32'(rejected_cnt), 32'd16);
    rd_en = 1'b0;
    gen_invalid_bit = 1'b0; gen_randnum = 32'hD000_0000; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_abort_done", 32'(done), 32'd1);
    chk("t3_abort_acc", 32'(accepted_cnt), 32'd18);
    chk("t3_abort_empty", 32'(fifo_empty), 32'd0);

    // T4: target 100, complete after 7 valid samples
    target_cnt = 16'd100; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t4_flush", 32'(fifo_empty), 32'd1);
    chk("t4_acc_clr", 32'(accepted_cnt), 32'd0);
    chk("t4_ovf_clr", 32'(overflow_cnt), 32'd0);
    chk("t4_rej_clr", 32'(rejected_cnt), 32'd0);
    for (int i = 0; i < 7; i++) begin
      gen_randnum = 32'hE000_0000 + 32'(i);
      step();
    end
    chk("t4_ctrl_pre", 32'(gen_control_bit), 32'd1);
    chk("t4_acc_pre", 32'(accepted_cnt), 32'd7);
    gen_complete_bit = 1'b1; gen_invalid_bit = 1'b1;
    step();
    gen_complete_bit = 1'b0; gen_invalid_bit = 1'b0;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_ctrl", 32'(gen_control_bit), 32'd0);
    chk("t4_exh", 32'(gen_exhausted), 32'd1);
    chk("t4_acc", 32'(accepted_cnt), 32'd7);
    chk("t4_rej", 32'(rejected_cnt), 32'd0);

    // T5: target 0
    target_cnt = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_arm_busy", 32'(busy), 32'd1);
    chk("t5_arm_ctrl", 32'(gen_control_bit), 32'd0);
    step();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_ctrl", 32'(gen_control_bit), 32'd0);
    chk("t5_acc", 32'(accepted_cnt), 32'd0);
    chk("t5_exh", 32'(gen_exhausted), 32'd0);

    // T6: reset mid-collect with 5 queued
    target_cnt = 16'd10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      gen_randnum = 32'hF000_0000 + 32'(i);
      step();
    end
    chk("t6_acc_pre", 32'(accepted_cnt), 32'd5);
    chk("t6_empty_pre", 32'(fifo_empty), 32'd0);
    reset = 1'b1; gen_invalid_bit = 1'b1;
    step();
    reset = 1'b0; gen_invalid_bit = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_empty", 32'(fifo_empty), 32'd1);
    chk("t6_acc", 32'(accepted_cnt), 32'd0);
    chk("t6_rej", 32'(rejected_cnt), 32'd0);
    chk("t6_nreset", 32'(gen_nreset), 32'd0);
    chk("t6_ctrl", 32'(gen_control_bit), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
